// File: rtl/hgfe_word_sequencer.sv
// Multi-digit HGFE to BCD front end: serialises a packed word of HGFE digits
// through one shared hgfe2dcba converter and returns the packed BCD word.

module hgfe2dcba (
  input  logic [3:0] hgfe,
  output logic [3:0] dcba,
  output logic       illegal
);

  always_comb begin
    dcba    = 4'h0;
    illegal = 1'b0;
    case (hgfe)
      4'b0000: dcba = 4'd0;
      4'b0001: dcba = 4'd1;
      4'b0011: dcba = 4'd2;
      4'b0100: dcba = 4'd3;
      4'b0101: dcba = 4'd4;
      4'b0111: dcba = 4'd5;
      4'b1001: dcba = 4'd6;
      4'b1011: dcba = 4'd7;
      4'b1100: dcba = 4'd8;
      4'b1101: dcba = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

module hgfe_word_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     out_err_mask,
  output logic                  out_err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [4*DIGITS-1:0]  code_q;

  logic [3:0]           cur_code;
  logic [3:0]           conv_dcba;
  logic                 conv_illegal;
  logic [4*DIGITS-1:0]  bcd_next;
  logic [DIGITS-1:0]    mask_next;

  // Digit select for the single shared converter.
  always_comb begin
    cur_code = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code = code_q[4*i +: 4];
      end
    end
  end

  hgfe2dcba u_conv (
    .hgfe    (cur_code),
    .dcba    (conv_dcba),
    .illegal (conv_illegal)
  );

  // Illegal digits are stored as 4'hF regardless of what the converter drives.
  always_comb begin
    bcd_next  = out_bcd;
    mask_next = out_err_mask;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        bcd_next[4*i +: 4] = conv_illegal ? 4'hF : conv_dcba;
        mask_next[i]       = conv_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      code_q       <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_bcd      <= '0;
      out_err_mask <= '0;
      out_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            code_q       <= in_code;
            idx          <= '0;
            out_bcd      <= '0;
            out_err_mask <= '0;
            out_err      <= 1'b0;
            in_ready     <= 1'b0;
            state        <= CONV;
          end
        end
        CONV: begin
          out_bcd      <= bcd_next;
          out_err_mask <= mask_next;
          out_err      <= |mask_next;
          if (idx == LAST_IDX) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hgfe_word_sequencer.sv
// Self-checking bench for hgfe_word_sequencer: directed words, per-position
// sweeps and random words checked against a table-lookup reference model.

module tb_hgfe_word_sequencer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_code = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_bcd;
  logic [DIGITS-1:0] out_err_mask;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  // Legal HGFE codes indexed by their decimal value.
  logic [3:0] legal_codes [10] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
                                   4'h7, 4'h9, 4'hB, 4'hC, 4'hD};

  hgfe_word_sequencer #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_bcd      (out_bcd),
    .out_err_mask (out_err_mask),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void ref_word(input logic [W-1:0] code,
                                   output logic [W-1:0] bcd,
                                   output logic [DIGITS-1:0] mask);
    bcd  = '0;
    mask = '0;
    for (int d = 0; d < DIGITS; d++) begin
      logic [3:0] c;
      bit found;
      c = code[4*d +: 4];
      found = 1'b0;
      for (int v = 0; v < 10; v++) begin
        if (legal_codes[v] == c) begin
          bcd[4*d +: 4] = 4'(v);
          found = 1'b1;
        end
      end
      if (!found) begin
        bcd[4*d +: 4] = 4'hF;
        mask[d] = 1'b1;
      end
    end
  endfunction

  function automatic logic [W-1:0] rand_legal_word();
    logic [W-1:0] w;
    w = '0;
    for (int d = 0; d < DIGITS; d++) w[4*d +: 4] = legal_codes[$urandom_range(9)];
    return w;
  endfunction

  // Offers one word, waits for the result (latency counted from acceptance), then acknowledges it.
  task automatic run_word(input logic [W-1:0] code, output logic [W-1:0] bcd,
                          output logic [DIGITS-1:0] mask, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_code  = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
    bcd  = out_bcd;
    mask = out_err_mask;
    err  = out_err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_bcd !== '0 || out_err_mask !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got bcd=%h mask=%b err=%b expected 0 0 0", out_bcd, out_err_mask, out_err);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_ignores_out_ready: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0]      codes [5] = '{16'h1345, 16'hDCB9, 16'h0000, 16'h0020, 16'hF86A};
    logic [W-1:0]      bcds  [5] = '{16'h1234, 16'h9876, 16'h0000, 16'h00F0, 16'hFFFF};
    logic [DIGITS-1:0] masks [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1111};
    logic [W-1:0] bcd;
    logic [DIGITS-1:0] mask;
    logic err;
    int lat;
    for (int k = 0; k < 5; k++) begin
      run_word(codes[k], bcd, mask, err, lat);
      checks++;
      if (lat != DIGITS) begin
        errors++;
        $display("[TB] FAIL directed_latency code=%h: got %0d expected %0d", codes[k], lat, DIGITS);
      end
      checks++;
      if (bcd !== bcds[k] || mask !== masks[k] || err !== (masks[k] != 0)) begin
        errors++;
        $display("[TB] FAIL directed code=%h: got bcd=%h mask=%b err=%b expected bcd=%h mask=%b err=%b",
                 codes[k], bcd, mask, err, bcds[k], masks[k], masks[k] != 0);
      end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] code, bcd, exp_bcd;
    logic [DIGITS-1:0] mask, exp_mask;
    logic err;
    int lat;
    for (int pos = 0; pos < DIGITS; pos++) begin
      for (int v = 0; v < 10; v++) begin
        code = rand_legal_word();
        code[4*pos +: 4] = legal_codes[v];
        ref_word(code, exp_bcd, exp_mask);
        run_word(code, bcd, mask, err, lat);
        checks++;
        if (bcd[4*pos +: 4] !== 4'(v) || bcd !== exp_bcd || mask !== '0 || err !== 1'b0 || lat != DIGITS) begin
          errors++;
          $display("[TB] FAIL sweep pos=%0d val=%0d: got bcd=%h mask=%b err=%b lat=%0d expected bcd=%h mask=0 err=0 lat=%0d",
                   pos, v, bcd, mask, err, lat, exp_bcd, DIGITS);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] code, bcd, exp_bcd;
    logic [DIGITS-1:0] mask, exp_mask;
    logic err;
    int lat;
    for (int k = 0; k < 30; k++) begin
      code = W'($urandom);
      ref_word(code, exp_bcd, exp_mask);
      run_word(code, bcd, mask, err, lat);
      checks++;
      if (bcd !== exp_bcd || mask !== exp_mask || err !== (|exp_mask) || lat != DIGITS) begin
        errors++;
        $display("[TB] FAIL random code=%h: got bcd=%h mask=%b err=%b lat=%0d expected bcd=%h mask=%b err=%b lat=%0d",
                 code, bcd, mask, err, lat, exp_bcd, exp_mask, |exp_mask, DIGITS);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] code, code2, exp_bcd, exp_bcd2;
    logic [DIGITS-1:0] exp_mask, exp_mask2;
    int lat;
    code = W'($urandom);
    ref_word(code, exp_bcd, exp_mask);
    in_code = code;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != DIGITS) begin
      errors++;
      $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, DIGITS);
    end
    for (int c = 0; c < 10; c++) begin
      in_code  = W'($urandom);
      in_valid = 1'($urandom_range(1));
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bcd !== exp_bcd ||
          out_err_mask !== exp_mask || out_err !== (|exp_mask)) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d: got valid=%b ready=%b bcd=%h mask=%b expected 1 0 %h %b",
                 c, out_valid, in_ready, out_bcd, out_err_mask, exp_bcd, exp_mask);
      end
    end
    code2 = W'($urandom);
    ref_word(code2, exp_bcd2, exp_mask2);
    in_code   = code2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = W'($urandom);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_next_accept: got in_ready=%b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != DIGITS || out_bcd !== exp_bcd2 || out_err_mask !== exp_mask2) begin
      errors++;
      $display("[TB] FAIL bp_next_word: got bcd=%h mask=%b lat=%0d expected %h %b %0d",
               out_bcd, out_err_mask, lat, exp_bcd2, exp_mask2, DIGITS);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] bcd;
    logic [DIGITS-1:0] mask;
    logic err;
    int lat;
    int stray;
    in_code  = 16'h1345;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 || out_err_mask !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got ready=%b valid=%b bcd=%h mask=%b err=%b expected 1 0 0 0 0",
               in_ready, out_valid, out_bcd, out_err_mask, out_err);
    end
    stray = 0;
    repeat (DIGITS + 2) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_discard: got %0d valid cycles expected 0", stray);
    end
    run_word(16'h1345, bcd, mask, err, lat);
    checks++;
    if (bcd !== 16'h1234 || mask !== '0 || err !== 1'b0 || lat != DIGITS) begin
      errors++;
      $display("[TB] FAIL mid_reset_recover: got bcd=%h mask=%b lat=%0d expected 1234 0 %0d", bcd, mask, lat, DIGITS);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 6;
    logic [W-1:0] code_q [$];
    logic [W-1:0] exp_bcd, hs_bcd, code;
    logic [DIGITS-1:0] exp_mask, hs_mask;
    int sent, got, cyc, last_hs, extra;
    bit acc, hs;
    sent = 0; got = 0; cyc = 0; last_hs = -1;
    code = W'($urandom);
    in_code   = code;
    out_ready = 1'b1;
    while (got < N && cyc < 200) begin
      in_valid = (sent < N);
      acc     = in_ready && in_valid;
      hs      = out_valid;
      hs_bcd  = out_bcd;
      hs_mask = out_err_mask;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        code_q.push_back(code);
        sent++;
        code = W'($urandom);
        in_code = code;
      end
      if (hs) begin
        checks++;
        if (code_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_duplicate: got extra result %h expected none", hs_bcd);
        end else begin
          ref_word(code_q.pop_front(), exp_bcd, exp_mask);
          if (hs_bcd !== exp_bcd || hs_mask !== exp_mask) begin
            errors++;
            $display("[TB] FAIL b2b_word %0d: got bcd=%h mask=%b expected %h %b", got, hs_bcd, hs_mask, exp_bcd, exp_mask);
          end
        end
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != DIGITS + 2) begin
            errors++;
            $display("[TB] FAIL b2b_interval: got %0d expected %0d", cyc - last_hs, DIGITS + 2);
          end
        end
        last_hs = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != N) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected %0d", got, N);
    end
    extra = 0;
    repeat (DIGITS + 3) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    out_ready = 1'b0;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL b2b_trailing: got %0d valid cycles expected 0", extra);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
